demux_1x16: RTL and testbench
=============================

Name: demux_1x16

Overview:
- Registered 1-to-DEPTH demultiplexer with valid/ready handshaking.
- Routes a single input word stream to one of DEPTH output lanes. It is the fan-out counterpart of the clocked 16x1 mux, so mux-side lanes can be fed from a single source.
- Each lane has a one-entry holding register. Routing is either addressed (select input) or round-robin (internal pointer).

Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of output lanes (2..16)
- SEL_W, $clog2(DEPTH), select/pointer width (derived, not overridden)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_data  input  WIDTH  input word
- in_valid  input  1  input word present
- in_ready  output  1  block accepts in_data this cycle
- s  input  SEL_W  target lane in addressed mode
- mode  input  1  0 = addressed (use s), 1 = round-robin (use rr_ptr)
- y  output  DEPTH*WIDTH  lane data; lane k occupies bits [k*WIDTH +: WIDTH]
- y_valid  output  DEPTH  lane k holds an undelivered word
- y_ready  input  DEPTH  lane k consumer takes its word this cycle
- occ  output  SEL_W+1  number of lanes with y_valid=1
- sel_err  output  1  one-cycle pulse: addressed word with s >= DEPTH was discarded

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous, active-high.
  - On rst: y=0, y_valid=0, occ=0, rr_ptr=0, sel_err=0.
  - in_ready is forced to 0 while rst=1.
- Target selection:
  - tgt = s when mode=0, tgt = rr_ptr when mode=1.
  - mode is sampled every cycle; rr_ptr keeps its value across mode changes.
- Lane state:
  - Each lane has a full flag (= y_valid[k]).
  - drain_k = y_valid[k] & y_ready[k].
- Ready rule (combinational, no combinational path from in_valid):
  - If tgt < DEPTH: in_ready = !y_valid[tgt] | y_ready[tgt].
  - If tgt >= DEPTH (addressed mode only): in_ready = 1.
- Accept = in_valid & in_ready.
- On accept with tgt < DEPTH, next cycle: y[tgt] = in_data and y_valid[tgt] = 1. Latency is 1 cycle from accept to y_valid.
- On accept with s >= DEPTH (mode=0): word is dropped, sel_err=1 next cycle, no lane changes.
- Drain: drain_k with no accept to lane k clears y_valid[k] next cycle. y[k] keeps its last value; it is not cleared.
- Simultaneous drain and accept on the same lane: y[k] takes the new word and y_valid[k] stays 1 (full-throughput pass-through).
- Accept to lane A and drains on other lanes in the same cycle are independent.
- Round-robin: rr_ptr advances only on an accept in mode=1. It wraps DEPTH-1 -> 0.
  - If the target lane is full and not draining, in_ready=0 and rr_ptr holds. The block does not skip to another lane; order is strictly sequential.
- occ is the registered popcount of y_valid, valid in the same cycle as y_valid. 0 <= occ <= DEPTH.
- Rst asserted mid-operation: all held words are discarded and y_valid=0 next cycle, regardless of y_ready.
- No combinational path from y_ready to y or y_valid. Only in_ready depends combinationally on y_ready, s and mode.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release → y=0, y_valid=16'h0000, occ=0, in_ready=1 after release.
- Addressed route: mode=0, s=4'd5, in_data=8'hA5, in_valid=1 for 1 cycle, y_ready=0 → next cycle y_valid=16'h0020, y[5]=8'hA5, occ=1. The following word to s=5 sees in_ready=0.
- Pass-through: lane 5 full with 8'hA5, y_ready[5]=1, new word 8'h3C to s=5 same cycle → in_ready=1, next cycle y[5]=8'h3C, y_valid[5]=1, occ=1.
- Round-robin sweep: mode=1, 17 words 8'h00..8'h10, all y_ready=1 → lane k receives k for k=0..15, then word 8'h10 lands on lane 0 (wrap), rr_ptr=1.
- Round-robin stall: mode=1, y_ready=0, 16 words accepted → occ=16, y_valid=16'hFFFF, in_ready=0, rr_ptr=0. Raising y_ready[0] only → in_ready=1 and the next word goes to lane 0.
- Bad select with DEPTH=10: mode=0, s=4'd12, in_valid=1 → in_ready=1, sel_err pulses 1 cycle, y_valid unchanged. Assert rst mid-stream with occ=3 → occ=0 next cycle.

Source files
------------

// File: rtl/demux_1x16.sv
// Registered 1-to-DEPTH demultiplexer with valid/ready handshaking.
// Each lane holds one word; the target lane is addressed (s) or round-robin.
module demux_1x16 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         s,
  input  logic                     mode,
  output logic [DEPTH*WIDTH-1:0]   y,
  output logic [DEPTH-1:0]         y_valid,
  input  logic [DEPTH-1:0]         y_ready,
  output logic [SEL_W:0]           occ,
  output logic                     sel_err
);

  logic [DEPTH*WIDTH-1:0] r_y;
  logic [DEPTH-1:0]       r_y_valid;
  logic [SEL_W:0]         r_occ;
  logic [SEL_W-1:0]       r_rr_ptr;
  logic                   r_sel_err;

  logic [SEL_W-1:0]       w_tgt;
  logic [DEPTH-1:0]       w_lane_hit;
  logic                   w_tgt_ok;
  logic                   w_in_ready;
  logic                   w_accept;
  logic [DEPTH-1:0]       w_load;
  logic [DEPTH-1:0]       w_valid_nxt;
  logic [SEL_W-1:0]       w_rr_nxt;

  function automatic logic [SEL_W:0] f_popcount(input logic [DEPTH-1:0] v);
    logic [SEL_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + (SEL_W+1)'(v[i]);
    end
    return cnt;
  endfunction

  // Target decode, ready rule and next-state computation.
  always_comb begin
    w_tgt = (mode == 1'b1) ? r_rr_ptr : s;
    w_lane_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_tgt == SEL_W'(k)) begin
        w_lane_hit[k] = 1'b1;
      end else begin
        w_lane_hit[k] = 1'b0;
      end
    end
    w_tgt_ok = (w_lane_hit != '0);
    if (rst) begin
      w_in_ready = 1'b0;
    end else if (w_tgt_ok) begin
      w_in_ready = |(w_lane_hit & (~r_y_valid | y_ready));
    end else begin
      w_in_ready = 1'b1;
    end
    w_accept    = in_valid & w_in_ready;
    w_load      = w_accept ? w_lane_hit : '0;
    w_valid_nxt = (r_y_valid & ~(r_y_valid & y_ready)) | w_load;
    if (w_accept && (mode == 1'b1)) begin
      if (r_rr_ptr == SEL_W'(DEPTH-1)) begin
        w_rr_nxt = '0;
      end else begin
        w_rr_nxt = r_rr_ptr + SEL_W'(1);
      end
    end else begin
      w_rr_nxt = r_rr_ptr;
    end
  end

  // Lane registers, occupancy, round-robin pointer and select-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y       <= '0;
      r_y_valid <= '0;
      r_occ     <= '0;
      r_rr_ptr  <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_y_valid <= w_valid_nxt;
      r_occ     <= f_popcount(w_valid_nxt);
      r_rr_ptr  <= w_rr_nxt;
      r_sel_err <= w_accept & ~w_tgt_ok;
      for (int k = 0; k < DEPTH; k++) begin
        if (w_load[k]) begin
          r_y[k*WIDTH +: WIDTH] <= in_data;
        end else begin
          r_y[k*WIDTH +: WIDTH] <= r_y[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign in_ready = w_in_ready;
  assign y        = r_y;
  assign y_valid  = r_y_valid;
  assign occ      = r_occ;
  assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_demux_1x16.sv
// Directed self-checking bench for demux_1x16 (DEPTH=16 and DEPTH=10 instances).
module tb_demux_1x16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   s;
  logic         mode;
  logic [127:0] y;
  logic [15:0]  y_valid;
  logic [15:0]  y_ready;
  logic [4:0]   occ;
  logic         sel_err;

  logic         rst10;
  logic [7:0]   in_data10;
  logic         in_valid10;
  logic         in_ready10;
  logic [3:0]   s10;
  logic         mode10;
  logic [79:0]  y10;
  logic [9:0]   y_valid10;
  logic [9:0]   y_ready10;
  logic [4:0]   occ10;
  logic         sel_err10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux_1x16 #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .s(s), .mode(mode), .y(y), .y_valid(y_valid),
    .y_ready(y_ready), .occ(occ), .sel_err(sel_err)
  );

  demux_1x16 #(.WIDTH(8), .DEPTH(10)) dut10 (
    .clk(clk), .rst(rst10), .in_data(in_data10), .in_valid(in_valid10),
    .in_ready(in_ready10), .s(s10), .mode(mode10), .y(y10), .y_valid(y_valid10),
    .y_ready(y_ready10), .occ(occ10), .sel_err(sel_err10)
  );

  function automatic logic [7:0] lane16(input int k);
    return y[k*8 +: 8];
  endfunction

  function automatic logic [7:0] lane10(input int k);
    return y10[k*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; s = 4'd0; in_valid = 1'b0; in_data = 8'h00; y_ready = 16'h0000;
    step(); step();
    rst = 1'b0;
    #1;
    n_tests++; if (y !== 128'h0) begin n_fail++; $display("FAIL reset_y got %h exp 0", y); end
    n_tests++; if (y_valid !== 16'h0000) begin n_fail++; $display("FAIL reset_y_valid got %h exp 0000", y_valid); end
    n_tests++; if (occ !== 5'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occ); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
  endtask

  task automatic test_addressed();
    mode = 1'b0; s = 4'd5; in_data = 8'hA5; in_valid = 1'b1; y_ready = 16'h0000;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addr_ready_empty got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    n_tests++; if (y_valid !== 16'h0020) begin n_fail++; $display("FAIL addr_y_valid got %h exp 0020", y_valid); end
    n_tests++; if (lane16(5) !== 8'hA5) begin n_fail++; $display("FAIL addr_lane5 got %h exp a5", lane16(5)); end
    n_tests++; if (occ !== 5'd1) begin n_fail++; $display("FAIL addr_occ got %0d exp 1", occ); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL addr_ready_full got %b exp 0", in_ready); end
    s = 4'd6;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addr_ready_other got %b exp 1", in_ready); end
  endtask

  task automatic test_pass_through();
    s = 4'd5; in_data = 8'h3C; in_valid = 1'b1; y_ready = 16'h0020;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pt_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0; y_ready = 16'h0000;
    #1;
    n_tests++; if (lane16(5) !== 8'h3C) begin n_fail++; $display("FAIL pt_lane5 got %h exp 3c", lane16(5)); end
    n_tests++; if (y_valid !== 16'h0020) begin n_fail++; $display("FAIL pt_y_valid got %h exp 0020", y_valid); end
    n_tests++; if (occ !== 5'd1) begin n_fail++; $display("FAIL pt_occ got %0d exp 1", occ); end
    y_ready = 16'h0020;
    step();
    y_ready = 16'h0000;
    n_tests++; if (y_valid !== 16'h0000) begin n_fail++; $display("FAIL drain_y_valid got %h exp 0000", y_valid); end
    n_tests++; if (lane16(5) !== 8'h3C) begin n_fail++; $display("FAIL drain_keeps_data got %h exp 3c", lane16(5)); end
    n_tests++; if (occ !== 5'd0) begin n_fail++; $display("FAIL drain_occ got %0d exp 0", occ); end
  endtask

  task automatic test_rr_sweep();
    mode = 1'b1; y_ready = 16'hFFFF; s = 4'd0;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_ready word %0d got %b exp 1", i, in_ready); end
      step();
      n_tests++; if (y_valid !== (16'h0001 << (i % 16))) begin n_fail++; $display("FAIL rr_y_valid word %0d got %h exp %h", i, y_valid, 16'h0001 << (i % 16)); end
      n_tests++; if (lane16(i % 16) !== 8'(i)) begin n_fail++; $display("FAIL rr_lane word %0d got %h exp %h", i, lane16(i % 16), 8'(i)); end
      n_tests++; if (occ !== 5'd1) begin n_fail++; $display("FAIL rr_occ word %0d got %0d exp 1", i, occ); end
    end
    in_data = 8'h55;
    step();
    in_valid = 1'b0;
    n_tests++; if (y_valid !== 16'h0002) begin n_fail++; $display("FAIL rr_ptr_after_wrap got %h exp 0002", y_valid); end
    n_tests++; if (lane16(1) !== 8'h55) begin n_fail++; $display("FAIL rr_lane1_after_wrap got %h exp 55", lane16(1)); end
    step();
    n_tests++; if (y_valid !== 16'h0000) begin n_fail++; $display("FAIL rr_final_drain got %h exp 0000", y_valid); end
  endtask

  task automatic test_rr_stall();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0; mode = 1'b1; y_ready = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'h80 + 8'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #1;
    n_tests++; if (occ !== 5'd16) begin n_fail++; $display("FAIL stall_occ got %0d exp 16", occ); end
    n_tests++; if (y_valid !== 16'hFFFF) begin n_fail++; $display("FAIL stall_y_valid got %h exp ffff", y_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", in_ready); end
    n_tests++; if (lane16(0) !== 8'h80) begin n_fail++; $display("FAIL stall_lane0 got %h exp 80", lane16(0)); end
    n_tests++; if (lane16(15) !== 8'h8F) begin n_fail++; $display("FAIL stall_lane15 got %h exp 8f", lane16(15)); end
    y_ready = 16'h0001; in_data = 8'hEE; in_valid = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
    step();
    y_ready = 16'h0004; in_data = 8'h77;
    #1;
    n_tests++; if (lane16(0) !== 8'hEE) begin n_fail++; $display("FAIL stall_lane0_new got %h exp ee", lane16(0)); end
    n_tests++; if (y_valid !== 16'hFFFF) begin n_fail++; $display("FAIL stall_refill got %h exp ffff", y_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_no_skip got %b exp 0", in_ready); end
    step();
    in_valid = 1'b0; y_ready = 16'h0000;
    n_tests++; if (y_valid !== 16'hFFFB) begin n_fail++; $display("FAIL stall_other_drain got %h exp fffb", y_valid); end
    n_tests++; if (lane16(1) !== 8'h81) begin n_fail++; $display("FAIL stall_lane1_kept got %h exp 81", lane16(1)); end
    n_tests++; if (occ !== 5'd15) begin n_fail++; $display("FAIL stall_occ15 got %0d exp 15", occ); end
  endtask

  task automatic test_bad_select();
    rst10 = 1'b1; mode10 = 1'b0; s10 = 4'd0; in_valid10 = 1'b0; in_data10 = 8'h00; y_ready10 = 10'h000;
    step();
    rst10 = 1'b0; s10 = 4'd12; in_data10 = 8'h99; in_valid10 = 1'b1;
    #1;
    n_tests++; if (in_ready10 !== 1'b1) begin n_fail++; $display("FAIL bad_sel_ready got %b exp 1", in_ready10); end
    step();
    in_valid10 = 1'b0;
    n_tests++; if (sel_err10 !== 1'b1) begin n_fail++; $display("FAIL bad_sel_pulse got %b exp 1", sel_err10); end
    n_tests++; if (y_valid10 !== 10'h000) begin n_fail++; $display("FAIL bad_sel_y_valid got %h exp 000", y_valid10); end
    n_tests++; if (occ10 !== 5'd0) begin n_fail++; $display("FAIL bad_sel_occ got %0d exp 0", occ10); end
    step();
    n_tests++; if (sel_err10 !== 1'b0) begin n_fail++; $display("FAIL bad_sel_one_cycle got %b exp 0", sel_err10); end
    s10 = 4'd10; in_valid10 = 1'b1;
    step();
    in_valid10 = 1'b0;
    n_tests++; if (sel_err10 !== 1'b1) begin n_fail++; $display("FAIL bad_sel_boundary got %b exp 1", sel_err10); end
    s10 = 4'd0; in_data10 = 8'h11; in_valid10 = 1'b1; step();
    s10 = 4'd3; in_data10 = 8'h22; step();
    s10 = 4'd9; in_data10 = 8'h33; step();
    in_valid10 = 1'b0;
    n_tests++; if (occ10 !== 5'd3) begin n_fail++; $display("FAIL d10_occ got %0d exp 3", occ10); end
    n_tests++; if (y_valid10 !== 10'h209) begin n_fail++; $display("FAIL d10_y_valid got %h exp 209", y_valid10); end
    n_tests++; if (lane10(9) !== 8'h33) begin n_fail++; $display("FAIL d10_lane9 got %h exp 33", lane10(9)); end
    rst10 = 1'b1; y_ready10 = 10'h000; in_valid10 = 1'b1; s10 = 4'd1;
    #1;
    n_tests++; if (in_ready10 !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", in_ready10); end
    step();
    rst10 = 1'b0; in_valid10 = 1'b0;
    n_tests++; if (occ10 !== 5'd0) begin n_fail++; $display("FAIL rst_mid_occ got %0d exp 0", occ10); end
    n_tests++; if (y_valid10 !== 10'h000) begin n_fail++; $display("FAIL rst_mid_y_valid got %h exp 000", y_valid10); end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; s = 4'd0; in_valid = 1'b0; in_data = 8'h00; y_ready = 16'h0000;
    rst10 = 1'b1; mode10 = 1'b0; s10 = 4'd0; in_valid10 = 1'b0; in_data10 = 8'h00; y_ready10 = 10'h000;
    test_reset();
    test_addressed();
    test_pass_through();
    test_rr_sweep();
    test_rr_stall();
    test_bad_select();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
